// File: rtl/scv_timing_gen.sv
// scv_timing_gen: CPU two-phase strobe sequencer with HOLD stall, plus an
// independent vertical-blank timer.
// Optional build macro SCV_TIMING_SIMVBL_EN forces both VBL intervals to
// 5000 cycles for fast boot-ROM simulation; when undefined the parameters
// VBL0_CLKS / VBL1_CLKS apply unchanged.
module scv_timing_gen #(
  parameter int VBL0_CLKS = 120872,
  parameter int VBL1_CLKS = 12464
) (
  input  logic CLK,
  input  logic RES,
  input  logic HOLD,
  output logic CP1_POSEDGE,
  output logic CP1_NEGEDGE,
  output logic CP2_POSEDGE,
  output logic CP2_NEGEDGE,
  output logic VBL,
  output logic VBL_START,
  output logic HELD
);

`ifdef SCV_TIMING_SIMVBL_EN
  localparam int VBL0_EFF = 5000;
  localparam int VBL1_EFF = 5000;
`else
  localparam int VBL0_EFF = VBL0_CLKS;
  localparam int VBL1_EFF = VBL1_CLKS;
`endif

  // Terminal counts: the counter reads 0 in the first cycle of each level.
  localparam logic [16:0] VBL0_LAST = 17'(VBL0_EFF - 1);
  localparam logic [16:0] VBL1_LAST = 17'(VBL1_EFF - 1);

  typedef enum logic [2:0] {
    P1P   = 3'd0,
    P1N   = 3'd1,
    P2P   = 3'd2,
    P2N   = 3'd3,
    STALL = 3'd4
  } phase_t;

  phase_t      state_q;
  phase_t      state_d;
  logic        rel_q;    // set during reset: next edge is the first after release
  logic [16:0] vcnt_q;

  // Phase state register; reset parks in P2N-equivalent idle.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= P2N;
      rel_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rel_q   <= 1'b0;
    end
  end

  // Next phase: HOLD only matters at the end of P2N or while stalled, so a
  // started 4-phase cycle always completes. Leaving reset ignores HOLD.
  always_comb begin
    state_d = state_q;
    if (rel_q) begin
      state_d = P1P;
    end else begin
      case (state_q)
        P1P:     state_d = P1N;
        P1N:     state_d = P2P;
        P2P:     state_d = P2N;
        P2N:     state_d = HOLD ? STALL : P1P;
        STALL:   state_d = HOLD ? STALL : P1P;
        default: state_d = P1P;
      endcase
    end
  end

  // Registered strobes and HELD decoded from the state being entered, so
  // they line up exactly with state_q.
  always_ff @(posedge CLK) begin
    if (RES) begin
      CP1_POSEDGE <= 1'b0;
      CP1_NEGEDGE <= 1'b0;
      CP2_POSEDGE <= 1'b0;
      CP2_NEGEDGE <= 1'b0;
      HELD        <= 1'b0;
    end else begin
      CP1_POSEDGE <= (state_d == P1P);
      CP1_NEGEDGE <= (state_d == P1N);
      CP2_POSEDGE <= (state_d == P2P);
      CP2_NEGEDGE <= (state_d == P2N);
      HELD        <= (state_d == STALL);
    end
  end

  // VBL timer: counts cycles within the current level and reloads to 0 on
  // every level change; it never looks at HOLD or the phase FSM.
  always_ff @(posedge CLK) begin
    if (RES) begin
      vcnt_q    <= '0;
      VBL       <= 1'b0;
      VBL_START <= 1'b0;
    end else begin
      VBL_START <= 1'b0;
      if (rel_q) begin
        vcnt_q <= '0;
      end else if (!VBL && (vcnt_q == VBL0_LAST)) begin
        VBL       <= 1'b1;
        VBL_START <= 1'b1;
        vcnt_q    <= '0;
      end else if (VBL && (vcnt_q == VBL1_LAST)) begin
        VBL    <= 1'b0;
        vcnt_q <= '0;
      end else begin
        vcnt_q <= vcnt_q + 17'd1;
      end
    end
  end

endmodule

// File: tb/tb_scv_timing_gen.sv
// tb_scv_timing_gen: scoreboard bench for scv_timing_gen with VBL0_CLKS=10,
// VBL1_CLKS=3 (5000/5000 when SCV_TIMING_SIMVBL_EN is defined).
module tb_scv_timing_gen;

`ifdef SCV_TIMING_SIMVBL_EN
  localparam int E0 = 5000;
  localparam int E1 = 5000;
`else
  localparam int E0 = 10;
  localparam int E1 = 3;
`endif
  localparam int FRAME = E0 + E1;

  logic CLK = 1'b0;
  logic RES = 1'b1;
  logic HOLD = 1'b0;
  logic CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE;
  logic VBL, VBL_START, HELD;

  scv_timing_gen #(.VBL0_CLKS(10), .VBL1_CLKS(3)) dut (
    .CLK         (CLK),
    .RES         (RES),
    .HOLD        (HOLD),
    .CP1_POSEDGE (CP1_POSEDGE),
    .CP1_NEGEDGE (CP1_NEGEDGE),
    .CP2_POSEDGE (CP2_POSEDGE),
    .CP2_NEGEDGE (CP2_NEGEDGE),
    .VBL         (VBL),
    .VBL_START   (VBL_START),
    .HELD        (HELD)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  string cur_tag = "reset";

  // Reference model state: idle flag, phase index (0..3 = P1P..P2N, 4 = stall),
  // and 1-based count of cycles since reset release.
  logic m_idle = 1'b1;
  int   m_ph   = 3;
  int   m_t    = 0;
  logic m_vbl  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge with the given inputs and return the
  // outputs expected after that edge: {CP1P,CP1N,CP2P,CP2N,VBL,VBL_START,HELD}.
  task automatic model_step(input logic r, input logic h, output logic [6:0] v);
    int pos;
    if (r) begin
      m_idle = 1'b1;
      m_ph   = 3;
      m_t    = 0;
    end else if (m_idle) begin
      m_idle = 1'b0;
      m_ph   = 0;
      m_t    = 1;
    end else begin
      if (m_ph >= 3) m_ph = h ? 4 : 0;
      else           m_ph = m_ph + 1;
      m_t++;
    end
    if (m_idle) begin
      m_vbl = 1'b0;
      v     = '0;
    end else begin
      pos   = (m_t - 1) % FRAME;
      m_vbl = (pos >= E0);
      v = {m_ph == 0, m_ph == 1, m_ph == 2, m_ph == 3, m_vbl, pos == E0, m_ph == 4};
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue its expectation.
  task automatic drive(input logic r, input logic h);
    exp_t e;
    @(negedge CLK);
    RES  = r;
    HOLD = h;
    model_step(r, h, e.v);
    e.tag = cur_tag;
    sb.push_back(e);
  endtask

  // Output monitor: compares DUT against the queued expectation after each edge.
  always @(posedge CLK) begin
    exp_t e;
    logic [3:0] strobes;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      strobes = {CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE};
      chk(e.tag, {25'd0, strobes, VBL, VBL_START, HELD}, {25'd0, e.v});
      chk({e.tag, "_onehot"}, 32'($countones(strobes) <= 1), 32'd1);
    end
  end

  initial begin
    logic found;
    // Reset held: everything 0.
    cur_tag = "reset";
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);

    // Free run from release; covers strobe rotation and two VBL frames.
    cur_tag = "run";
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b0);

    // Raise HOLD during CP1_NEGEDGE, keep it 50 cycles, then drop.
    cur_tag = "hold_align";
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      drive(1'b0, 1'b0);
      if (m_ph == 1) found = 1'b1;
    end
    chk("reach_p1n", 32'(found), 32'd1);
    cur_tag = "hold";
    for (int i = 0; i < 50; i++) drive(1'b0, 1'b1);
    cur_tag = "hold_release";
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0);

    // Random HOLD activity.
    cur_tag = "rand";
    for (int i = 0; i < 150; i++) drive(1'b0, 1'($urandom_range(0, 1)));

    // Reset pulse while VBL high and stalled.
    cur_tag = "seek_vbl_stall";
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME + 8 && !found; i++) begin
      drive(1'b0, 1'b1);
      if (m_vbl && m_ph == 4) found = 1'b1;
    end
    chk("reach_vbl_stall", 32'(found), 32'd1);
    cur_tag = "rstpulse";
    drive(1'b1, 1'b1);
    cur_tag = "release_hold";
    drive(1'b0, 1'b1);
    cur_tag = "post_reset";
    for (int i = 0; i < FRAME + 5; i++) drive(1'b0, 1'b0);

    @(posedge CLK);
    #2;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
